// File: rtl/icache.sv
// Set-associative L1 instruction cache: line read buffer, round-robin refill,
// fence.i flush and 32-bit fetches that straddle two lines.
module icache #(
    parameter int WAYS = 2,
    parameter int SETS = 64,
    parameter int LINE = 256,
    localparam int OFFS = $clog2(LINE / 8),
    localparam int SETL = $clog2(SETS),
    localparam int TAGL = 64 - OFFS - SETL,
    localparam int BLK  = 64 - OFFS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [63:0]     pc,
    output logic [31:0]     ir,
    input  logic            stall,
    output logic            stall_imem,
    input  logic            flush,
    output logic [BLK-1:0]  b_addr_i,
    output logic            b_rd_i,
    input  logic [LINE-1:0] b_data_i,
    input  logic            b_dv_i
);
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int IDXW = $clog2(WAYS * SETS);
    localparam logic [OFFS-1:0] MA_OFF = OFFS'(LINE / 8 - 2);

    typedef enum logic [2:0] {READY, LOOKUP, LOAD, FETCH, MA} state_e;

    state_e          state_q, state_d;
    logic [LINE-1:0] rb_q, rb_d;
    logic [BLK-1:0]  rb_la_q, rb_la_d;
    logic            rb_v_q, rb_v_d;
    logic            ma_v_q, ma_v_d;
    logic [BLK-1:0]  ma_la_q, ma_la_d;
    logic [15:0]     ma_lo_q, ma_lo_d;
    logic            flush_pend_q, flush_pend_d;
    logic [BLK-1:0]  b_addr_q, b_addr_d;
    logic [WAYS*SETS-1:0] valid_q, valid_d;
    logic [WW-1:0]   rr_q [SETS];
    logic [WW-1:0]   rr_d [SETS];
    logic [TAGL-1:0] tag_q [WAYS*SETS];
    logic [TAGL-1:0] tag_d;
    logic [LINE-1:0] data_mem [WAYS*SETS];
    logic [LINE-1:0] q;

    logic            we, re;
    logic [IDXW-1:0] widx, ridx;
    logic [BLK-1:0]  line_pc, line_pc2, tl;
    logic [OFFS-1:0] off;
    logic            ma, ma_cap, buf_hit, inval;
    logic [SETL-1:0] tl_set, f_set;
    logic [TAGL-1:0] tl_tag;
    logic            lk_hit;
    logic [WW-1:0]   lk_way, vic;
    logic            vic_found;
    logic [31:0]     ir_al;

    function automatic logic [IDXW-1:0] idx(input logic [SETL-1:0] s, input logic [WW-1:0] w);
        return IDXW'(int'(s) * WAYS + int'(w));
    endfunction

    // pc+2 lands in the next line exactly when pc sits on the last halfword.
    assign off      = pc[OFFS-1:0];
    assign ma       = (off == MA_OFF);
    assign line_pc  = pc[63:OFFS];
    assign line_pc2 = line_pc + BLK'(ma);
    assign ma_cap   = ma && ma_v_q && (ma_la_q == line_pc);
    assign tl       = ma_cap ? line_pc2 : line_pc;
    assign tl_set   = tl[SETL-1:0];
    assign tl_tag   = tl[BLK-1:SETL];
    assign f_set    = b_addr_q[SETL-1:0];
    assign tag_d    = b_addr_q[BLK-1:SETL];
    assign buf_hit  = rb_v_q && (ma ? (rb_la_q == line_pc2 && ma_cap) : (rb_la_q == line_pc));
    assign inval    = flush || flush_pend_q;

    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!lk_hit && valid_q[idx(tl_set, WW'(w))] && tag_q[idx(tl_set, WW'(w))] == tl_tag) begin
                lk_hit = 1'b1;
                lk_way = WW'(w);
            end
        end
    end

    always_comb begin
        vic_found = 1'b0;
        vic       = rr_q[f_set];
        for (int w = 0; w < WAYS; w++) begin
            if (!vic_found && !valid_q[idx(f_set, WW'(w))]) begin
                vic_found = 1'b1;
                vic       = WW'(w);
            end
        end
    end

    // NOTE: every variable gets its default first so no path through the case can infer a latch.
    always_comb begin
        state_d      = state_q;
        rb_d         = rb_q;
        rb_la_d      = rb_la_q;
        rb_v_d       = rb_v_q;
        ma_v_d       = ma_v_q;
        ma_la_d      = ma_la_q;
        ma_lo_d      = ma_lo_q;
        flush_pend_d = flush_pend_q;
        b_addr_d     = b_addr_q;
        valid_d      = valid_q;
        rr_d         = rr_q;
        we           = 1'b0;
        re           = 1'b0;
        widx         = idx(f_set, vic);
        ridx         = idx(tl_set, lk_way);
        unique case (state_q)
            READY: begin
                if (inval) begin
                    valid_d      = '0;
                    rb_v_d       = 1'b0;
                    ma_v_d       = 1'b0;
                    flush_pend_d = 1'b0;
                    for (int s = 0; s < SETS; s++) rr_d[s] = '0;
                end
                if (buf_hit || stall) state_d = READY;
                else if (ma && rb_v_q && rb_la_q == line_pc && !inval) state_d = MA;
                else state_d = LOOKUP;
            end
            LOOKUP: begin
                if (lk_hit) begin
                    re      = 1'b1;
                    state_d = LOAD;
                end else begin
                    b_addr_d = tl;
                    state_d  = FETCH;
                end
            end
            LOAD: begin
                rb_d    = q;
                rb_la_d = tl;
                rb_v_d  = 1'b1;
                state_d = (ma && !ma_cap) ? MA : READY;
            end
            FETCH: begin
                if (b_dv_i) begin
                    we            = 1'b1;
                    valid_d[widx] = 1'b1;
                    rr_d[f_set]   = (rr_q[f_set] == WW'(WAYS - 1)) ? '0 : rr_q[f_set] + 1'b1;
                    rb_d          = b_data_i;
                    rb_la_d       = b_addr_q;
                    rb_v_d        = 1'b1;
                    state_d       = (ma && !ma_cap) ? MA : READY;
                end
            end
            MA: begin
                ma_lo_d = rb_q[LINE-1 -: 16];
                ma_la_d = rb_la_q;
                ma_v_d  = 1'b1;
                // rb holds line(pc) here, so it can never already cover line(pc+2).
                state_d = LOOKUP;
            end
            default: state_d = READY;
        endcase
        if (flush && state_q != READY) flush_pend_d = 1'b1;
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= READY;
            rb_q         <= '0;
            rb_la_q      <= '0;
            rb_v_q       <= 1'b0;
            ma_v_q       <= 1'b0;
            ma_la_q      <= '0;
            ma_lo_q      <= '0;
            flush_pend_q <= 1'b0;
            b_addr_q     <= '0;
            valid_q      <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            state_q      <= state_d;
            rb_q         <= rb_d;
            rb_la_q      <= rb_la_d;
            rb_v_q       <= rb_v_d;
            ma_v_q       <= ma_v_d;
            ma_la_q      <= ma_la_d;
            ma_lo_q      <= ma_lo_d;
            flush_pend_q <= flush_pend_d;
            b_addr_q     <= b_addr_d;
            valid_q      <= valid_d;
            rr_q         <= rr_d;
        end
    end

    // NOTE: data and tag arrays are not reset; the valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (we) begin
            data_mem[widx] <= b_data_i;
            tag_q[widx]    <= tag_d;
        end
        if (re) q <= data_mem[ridx];
    end

    always_comb begin
        ir_al = '0;
        for (int b = 0; b <= LINE / 8 - 4; b += 2) begin
            if (off == OFFS'(b)) ir_al = rb_q[8*b +: 32];
        end
    end

    assign ir         = ma ? {rb_q[15:0], ma_lo_q} : ir_al;
    assign b_rd_i     = (state_q == FETCH);
    assign b_addr_i   = b_addr_q;
    assign stall_imem = (stall && state_q == READY) ? 1'b0
                      : ((state_q != READY) || !buf_hit || (state_d != READY));
endmodule
